// File: rtl/axi4_mem_sub_pkg.sv
//------------------------------------------------------------------------------
// axi4_mem_sub_pkg : shared AXI4 channel types, burst/resp encodings, FSM states
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axi4_mem_sub_pkg;

  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_ID_R_W = 3;
  localparam int unsigned AXI_ID_W_W = 2;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2,
    R_SEND  = 2'd3
  } r_state_e;

  typedef struct packed {
    logic [AXI_ID_W_W-1:0] id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W_W-1:0] id;
    logic [1:0]            resp;
  } b_chan_t;

  typedef struct packed {
    logic [AXI_ID_R_W-1:0] id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_chan_t;

  typedef struct packed {
    logic [AXI_ID_R_W-1:0] id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } mem_sub_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     w_ready;
    b_chan_t  b;
    logic     b_valid;
    logic     ar_ready;
    r_chan_t  r;
    logic     r_valid;
  } mem_sub_resp_t;

endpackage

`default_nettype wire

// File: rtl/axi4_burst_addr_gen.sv
//------------------------------------------------------------------------------
// axi4_burst_addr_gen : combinational AXI4 beat address and burst-legality check
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi4_burst_addr_gen
  import axi4_mem_sub_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  input  logic [7:0]            i_beat,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_err
);

  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic                  w_len_ok;

  always_comb begin
    w_aligned = (i_addr >> i_size) << i_size;
    w_incr    = w_aligned + (ADDR_WIDTH'(i_beat) << i_size);
    // wrap container is (len+1) transfers of 2^size bytes, naturally aligned
    w_mask    = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);
    w_len_ok  = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
    o_err     = 1'b0;
    o_addr    = i_addr;
    case (burst_e'(i_burst))
      FIXED: o_addr = i_addr;
      INCR:  o_addr = (i_beat == 8'd0) ? i_addr : w_incr;
      WRAP: begin
        o_err  = !w_len_ok;
        o_addr = (i_beat == 8'd0) ? i_addr : ((i_addr & ~w_mask) | (w_incr & w_mask));
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/axi4_mem_sub.sv
//------------------------------------------------------------------------------
// axi4_mem_sub : AXI4 subordinate serving bursts from a single-port memory
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi4_mem_sub
  import axi4_mem_sub_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_R_WIDTH = 3,
  parameter int unsigned ID_W_WIDTH = 2,
  parameter type         axi_req_t  = mem_sub_req_t,
  parameter type         axi_resp_t = mem_sub_resp_t
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  axi_req_t                axi_req_i,
  output axi_resp_t               axi_resp_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_strb_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned OFFS = $clog2(DATA_WIDTH / 8);

  w_state_e r_wstate, w_wstate_nxt;
  r_state_e r_rstate, w_rstate_nxt;

  logic [ID_W_WIDTH-1:0] r_aw_id;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [7:0]            r_aw_len, r_w_beat;
  logic [2:0]            r_aw_size;
  logic [1:0]            r_aw_burst;
  logic                  r_w_err;

  logic [ID_R_WIDTH-1:0] r_ar_id;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [7:0]            r_ar_len, r_r_beat;
  logic [2:0]            r_ar_size;
  logic [1:0]            r_ar_burst, r_r_resp;
  logic [DATA_WIDTH-1:0] r_r_data;
  logic                  r_r_last;
  logic                  r_prio_rd;

  logic [ADDR_WIDTH-1:0] w_waddr, w_raddr, w_sel_addr;
  logic                  w_wbad, w_rbad, w_run;
  logic                  w_wmem, w_rmem, w_wgnt, w_rgnt, w_whs;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wgen (
    .i_addr(r_aw_addr), .i_len(r_aw_len), .i_size(r_aw_size), .i_burst(r_aw_burst),
    .i_beat(r_w_beat), .o_addr(w_waddr), .o_err(w_wbad)
  );

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgen (
    .i_addr(r_ar_addr), .i_len(r_ar_len), .i_size(r_ar_size), .i_burst(r_ar_burst),
    .i_beat(r_r_beat), .o_addr(w_raddr), .o_err(w_rbad)
  );

  // Illegal bursts never touch the memory, so they bypass arbitration entirely.
  always_comb begin
    w_run  = !srst_i;
    w_wmem = w_run && (r_wstate == W_DATA) && axi_req_i.w_valid && !w_wbad;
    w_rmem = w_run && (r_rstate == R_ISSUE) && !w_rbad;
    w_wgnt = w_wmem && (!w_rmem || !r_prio_rd);
    w_rgnt = w_rmem && (!w_wmem || r_prio_rd);
    w_whs  = w_run && (r_wstate == W_DATA) && axi_req_i.w_valid && (w_wgnt || w_wbad);
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (axi_req_i.aw_valid) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_whs && (r_w_beat == r_aw_len)) w_wstate_nxt = W_RESP;
      W_RESP:  if (axi_req_i.b_ready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (axi_req_i.ar_valid) w_rstate_nxt = R_ISSUE;
      R_ISSUE: if (w_rgnt || w_rbad) w_rstate_nxt = R_WAIT;
      R_WAIT:  w_rstate_nxt = R_SEND;
      R_SEND:  if (axi_req_i.r_ready) w_rstate_nxt = r_r_last ? R_IDLE : R_ISSUE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_wstate  <= W_IDLE;
      r_rstate  <= R_IDLE;
      r_prio_rd <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_rstate  <= w_rstate_nxt;
      if (w_wmem && w_rmem) r_prio_rd <= !r_prio_rd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_aw_id <= '0; r_aw_addr <= '0; r_aw_len <= '0; r_aw_size <= '0; r_aw_burst <= '0;
      r_w_beat <= '0; r_w_err <= 1'b0;
      r_ar_id <= '0; r_ar_addr <= '0; r_ar_len <= '0; r_ar_size <= '0; r_ar_burst <= '0;
      r_r_beat <= '0; r_r_data <= '0; r_r_resp <= OKAY; r_r_last <= 1'b0;
    end else begin
      if ((r_wstate == W_IDLE) && axi_req_i.aw_valid) begin
        r_aw_id    <= axi_req_i.aw.id;
        r_aw_addr  <= axi_req_i.aw.addr;
        r_aw_len   <= axi_req_i.aw.len;
        r_aw_size  <= axi_req_i.aw.size;
        r_aw_burst <= axi_req_i.aw.burst;
        r_w_beat   <= '0;
        r_w_err    <= 1'b0;
      end
      if (w_whs) begin
        r_w_beat <= r_w_beat + 8'd1;
        if (axi_req_i.w.last != (r_w_beat == r_aw_len)) r_w_err <= 1'b1;
      end
      if ((r_rstate == R_IDLE) && axi_req_i.ar_valid) begin
        r_ar_id    <= axi_req_i.ar.id;
        r_ar_addr  <= axi_req_i.ar.addr;
        r_ar_len   <= axi_req_i.ar.len;
        r_ar_size  <= axi_req_i.ar.size;
        r_ar_burst <= axi_req_i.ar.burst;
        r_r_beat   <= '0;
      end
      if (r_rstate == R_WAIT) begin
        r_r_data <= w_rbad ? '0 : mem_rdata_i;
        r_r_resp <= w_rbad ? SLVERR : OKAY;
        r_r_last <= (r_r_beat == r_ar_len);
      end
      if ((r_rstate == R_SEND) && axi_req_i.r_ready) r_r_beat <= r_r_beat + 8'd1;
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = w_run && (r_wstate == W_IDLE);
    axi_resp_o.w_ready  = w_run && (r_wstate == W_DATA) && (w_wgnt || w_wbad);
    axi_resp_o.b_valid  = w_run && (r_wstate == W_RESP);
    axi_resp_o.b.id     = r_aw_id;
    axi_resp_o.b.resp   = (r_w_err || w_wbad) ? SLVERR : OKAY;
    axi_resp_o.ar_ready = w_run && (r_rstate == R_IDLE);
    axi_resp_o.r_valid  = w_run && (r_rstate == R_SEND);
    axi_resp_o.r.id     = r_ar_id;
    axi_resp_o.r.data   = r_r_data;
    axi_resp_o.r.resp   = r_r_resp;
    axi_resp_o.r.last   = r_r_last;
  end

  always_comb begin
    w_sel_addr  = w_wgnt ? w_waddr : w_raddr;
    mem_req_o   = w_wgnt || w_rgnt;
    mem_we_o    = w_wgnt;
    mem_addr_o  = (w_sel_addr >> OFFS) << OFFS;
    mem_wdata_o = axi_req_i.w.data;
    mem_strb_o  = axi_req_i.w.strb;
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4_mem_sub.sv
//------------------------------------------------------------------------------
// tb_axi4_mem_sub : directed self-checking bench for axi4_mem_sub
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi4_mem_sub;
  import axi4_mem_sub_pkg::*;

  logic          clk = 1'b0;
  logic          srst;
  mem_sub_req_t  req;
  mem_sub_resp_t resp;
  logic          mem_req, mem_we;
  logic [63:0]   mem_addr, mem_wdata;
  logic [7:0]    mem_strb;
  logic [63:0]   mem_rdata = '0;
  int unsigned   n_acc = 0;
  int unsigned   base;
  int            total = 0;
  int            bad = 0;
  logic [63:0]   wrap_exp [4];

  always #5 clk = ~clk;

  axi4_mem_sub #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_R_WIDTH(3), .ID_W_WIDTH(2),
    .axi_req_t(mem_sub_req_t), .axi_resp_t(mem_sub_resp_t)
  ) dut (
    .clk_i(clk), .srst_i(srst), .axi_req_i(req), .axi_resp_o(resp),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [63:0] pat(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  // memory model: read data valid the cycle after the request
  always @(posedge clk) begin
    if (mem_req) begin
      n_acc <= n_acc + 1;
      if (!mem_we) mem_rdata <= pat(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    req  = '0;
    srst = 1'b1;
    wrap_exp[0] = 64'h38; wrap_exp[1] = 64'h20; wrap_exp[2] = 64'h28; wrap_exp[3] = 64'h30;

    // reset
    @(negedge clk); #1;
    chk("rst_aw_ready", 64'(resp.aw_ready), 64'd0);
    chk("rst_ar_ready", 64'(resp.ar_ready), 64'd0);
    chk("rst_b_valid", 64'(resp.b_valid), 64'd0);
    chk("rst_r_valid", 64'(resp.r_valid), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    @(negedge clk); srst = 1'b0; #1;
    chk("post_rst_aw_ready", 64'(resp.aw_ready), 64'd1);
    chk("post_rst_ar_ready", 64'(resp.ar_ready), 64'd1);
    chk("post_rst_b_id", 64'(resp.b.id), 64'd0);
    chk("post_rst_r_data", resp.r.data, 64'd0);

    // INCR write burst
    @(negedge clk);
    req.aw_valid = 1'b1;
    req.aw.id = 2'd1; req.aw.addr = 64'h100; req.aw.len = 8'd3; req.aw.size = 3'd3; req.aw.burst = INCR;
    #1 chk("wr_aw_ready", 64'(resp.aw_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req.aw_valid = 1'b0;
      req.w_valid = 1'b1; req.w.data = 64'hA5A5_0000_0000_0000 + 64'(i);
      req.w.strb = 8'hFF; req.w.last = (i == 3);
      #1;
      chk("wr_addr", mem_addr, 64'h100 + 64'(8 * i));
      chk("wr_req_we", 64'({mem_req, mem_we}), 64'd3);
      chk("wr_wdata", mem_wdata, 64'hA5A5_0000_0000_0000 + 64'(i));
    end
    @(negedge clk); req.w_valid = 1'b0; #1;
    chk("wr_b_valid", 64'(resp.b_valid), 64'd1);
    chk("wr_b_id", 64'(resp.b.id), 64'd1);
    chk("wr_b_resp", 64'(resp.b.resp), 64'd0);
    req.b_ready = 1'b1;
    @(negedge clk); req.b_ready = 1'b0; #1;
    chk("wr_b_done", 64'(resp.b_valid), 64'd0);
    chk("wr_aw_ready_back", 64'(resp.aw_ready), 64'd1);

    // WRAP read burst
    @(negedge clk);
    req.ar_valid = 1'b1; req.r_ready = 1'b1;
    req.ar.id = 3'd5; req.ar.addr = 64'h38; req.ar.len = 8'd3; req.ar.size = 3'd3; req.ar.burst = WRAP;
    #1 chk("rd_ar_ready", 64'(resp.ar_ready), 64'd1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); req.ar_valid = 1'b0; #1;
      chk("rd_wrap_addr", mem_addr, wrap_exp[b]);
      chk("rd_req_we", 64'({mem_req, mem_we}), 64'd2);
      @(negedge clk);
      @(negedge clk); #1;
      chk("rd_r_valid", 64'(resp.r_valid), 64'd1);
      chk("rd_r_data", resp.r.data, pat(wrap_exp[b]));
      chk("rd_r_last", 64'(resp.r.last), 64'(b == 3));
      chk("rd_r_id", 64'(resp.r.id), 64'd5);
    end
    @(negedge clk); #1 chk("rd_ar_ready_back", 64'(resp.ar_ready), 64'd1);

    // R channel backpressure
    @(negedge clk);
    req.ar_valid = 1'b1; req.r_ready = 1'b0;
    req.ar.id = 3'd2; req.ar.addr = 64'h400; req.ar.len = 8'd0; req.ar.size = 3'd3; req.ar.burst = INCR;
    @(negedge clk); req.ar_valid = 1'b0; base = n_acc; #1;
    chk("stall_issue_addr", mem_addr, 64'h400);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("stall_r_valid", 64'(resp.r_valid), 64'd1);
      chk("stall_r_data", resp.r.data, pat(64'h400));
      chk("stall_no_req", 64'(mem_req), 64'd0);
    end
    @(negedge clk); req.r_ready = 1'b1; #1;
    chk("stall_r_valid_end", 64'(resp.r_valid), 64'd1);
    @(negedge clk); req.r_ready = 1'b0; #1;
    chk("stall_ar_ready", 64'(resp.ar_ready), 64'd1);
    chk("stall_acc_count", 64'(n_acc - base), 64'd1);

    // contested arbitration: W,R,W,R on contested cycles
    @(negedge clk);
    req.aw_valid = 1'b1; req.ar_valid = 1'b1; req.r_ready = 1'b1; req.b_ready = 1'b0;
    req.aw.id = 2'd2; req.aw.addr = 64'h200; req.aw.len = 8'd3; req.aw.size = 3'd3; req.aw.burst = INCR;
    req.ar.id = 3'd1; req.ar.addr = 64'h300; req.ar.len = 8'd1; req.ar.size = 3'd3; req.ar.burst = INCR;
    #1 chk("arb_both_ready", 64'({resp.aw_ready, resp.ar_ready}), 64'd3);
    @(negedge clk);
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    req.w_valid = 1'b1; req.w.data = 64'hB0; req.w.last = 1'b0; #1;
    chk("arb_a_we", 64'({mem_req, mem_we}), 64'd3);
    chk("arb_a_addr", mem_addr, 64'h200);
    @(negedge clk); req.w.data = 64'hB1; #1;
    chk("arb_b_rd", 64'({mem_req, mem_we}), 64'd2);
    chk("arb_b_addr", mem_addr, 64'h300);
    chk("arb_b_w_ready", 64'(resp.w_ready), 64'd0);
    @(negedge clk); #1;
    chk("arb_c_we", 64'({mem_req, mem_we}), 64'd3);
    chk("arb_c_addr", mem_addr, 64'h208);
    @(negedge clk); req.w_valid = 1'b0; #1;
    chk("arb_d_r_data", resp.r.data, pat(64'h300));
    chk("arb_d_no_req", 64'(mem_req), 64'd0);
    @(negedge clk); req.w_valid = 1'b1; req.w.data = 64'hB2; #1;
    chk("arb_e_we", 64'({mem_req, mem_we}), 64'd3);
    chk("arb_e_addr", mem_addr, 64'h210);
    @(negedge clk); req.w.data = 64'hB3; req.w.last = 1'b1; #1;
    chk("arb_f_rd", 64'({mem_req, mem_we}), 64'd2);
    chk("arb_f_addr", mem_addr, 64'h308);
    @(negedge clk); #1;
    chk("arb_g_we", 64'({mem_req, mem_we}), 64'd3);
    chk("arb_g_addr", mem_addr, 64'h218);
    chk("arb_g_wdata", mem_wdata, 64'hB3);
    @(negedge clk); req.w_valid = 1'b0; req.b_ready = 1'b1; #1;
    chk("arb_h_r_data", resp.r.data, pat(64'h308));
    chk("arb_h_r_last", 64'(resp.r.last), 64'd1);
    chk("arb_h_b_valid", 64'(resp.b_valid), 64'd1);
    chk("arb_h_b_id", 64'(resp.b.id), 64'd2);
    @(negedge clk); req.b_ready = 1'b0; #1;
    chk("arb_idle", 64'({resp.aw_ready, resp.ar_ready}), 64'd3);

    // INCR across the top of the address space with wrong WLAST
    @(negedge clk);
    req.aw_valid = 1'b1;
    req.aw.id = 2'd3; req.aw.addr = 64'hFFFF_FFFF_FFFF_FFF8; req.aw.len = 8'd1; req.aw.size = 3'd3;
    req.aw.burst = INCR;
    @(negedge clk); req.aw_valid = 1'b0; req.w_valid = 1'b1; req.w.last = 1'b0; #1;
    chk("top_addr0", mem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    @(negedge clk); #1;
    chk("top_addr1", mem_addr, 64'h0);
    @(negedge clk); req.w_valid = 1'b0; #1;
    chk("wlast_b_resp", 64'(resp.b.resp), 64'(SLVERR));
    chk("wlast_b_id", 64'(resp.b.id), 64'd3);
    req.b_ready = 1'b1;
    @(negedge clk); req.b_ready = 1'b0;

    // reserved burst read
    @(negedge clk);
    req.ar_valid = 1'b1; req.r_ready = 1'b1; base = n_acc;
    req.ar.id = 3'd4; req.ar.addr = 64'h500; req.ar.len = 8'd1; req.ar.size = 3'd3; req.ar.burst = 2'b11;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); req.ar_valid = 1'b0; #1;
      chk("rsv_no_req", 64'(mem_req), 64'd0);
      @(negedge clk);
      @(negedge clk); #1;
      chk("rsv_r_valid", 64'(resp.r_valid), 64'd1);
      chk("rsv_r_resp", 64'(resp.r.resp), 64'(SLVERR));
      chk("rsv_r_data", resp.r.data, 64'd0);
      chk("rsv_r_last", 64'(resp.r.last), 64'(b == 1));
    end
    @(negedge clk); #1;
    chk("rsv_ar_ready", 64'(resp.ar_ready), 64'd1);
    chk("rsv_acc_count", 64'(n_acc - base), 64'd0);

    // reset in the middle of a write burst
    @(negedge clk);
    req.aw_valid = 1'b1;
    req.aw.id = 2'd1; req.aw.addr = 64'h700; req.aw.len = 8'd3; req.aw.size = 3'd3; req.aw.burst = INCR;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); req.aw_valid = 1'b0; req.w_valid = 1'b1; req.w.last = 1'b0; #1;
      chk("mid_wr_addr", mem_addr, 64'h700 + 64'(8 * i));
    end
    @(negedge clk); srst = 1'b1; base = n_acc; #1;
    chk("mid_rst_no_req", 64'(mem_req), 64'd0);
    @(negedge clk); srst = 1'b0; #1;
    chk("mid_aw_ready", 64'(resp.aw_ready), 64'd1);
    chk("mid_w_ready", 64'(resp.w_ready), 64'd0);
    chk("mid_no_req", 64'(mem_req), 64'd0);
    @(negedge clk); req.w_valid = 1'b0; #1;
    chk("mid_no_b", 64'(resp.b_valid), 64'd0);
    @(negedge clk); #1;
    chk("mid_acc_count", 64'(n_acc - base), 64'd0);
    chk("mid_no_b_late", 64'(resp.b_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
